// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and defaults for the MEM pipeline stage.
//   state_t        - MEM-stage FSM encoding (IDLE/BUSY/DONE)
//   DATA_W_DEF     - default data/address width
//   TIMEOUT_CYC_DEF- default number of BUSY cycles before a memory abort
package mem_stage_pkg;
  localparam int DATA_W_DEF      = 16;
  localparam int TIMEOUT_CYC_DEF = 15;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory handshake between the MEM stage and memory.
//   Mem_Req   - one-cycle request pulse (master -> slave)
//   Mem_Wr    - 1 = store, 0 = load, valid with Mem_Req
//   Mem_Addr  - access address
//   Mem_WData - store data
//   Mem_Ack   - one-cycle completion pulse (slave -> master)
//   Mem_RData - load data, valid while Mem_Ack=1
interface mem_stage_if #(parameter int DATA_W = mem_stage_pkg::DATA_W_DEF);
  logic              Mem_Req;
  logic              Mem_Wr;
  logic [DATA_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Mem_WData;
  logic              Mem_Ack;
  logic [DATA_W-1:0] Mem_RData;

  modport master (output Mem_Req, Mem_Wr, Mem_Addr, Mem_WData,
                  input  Mem_Ack, Mem_RData);
  modport slave  (input  Mem_Req, Mem_Wr, Mem_Addr, Mem_WData,
                  output Mem_Ack, Mem_RData);
endinterface

// File: rtl/mem_stage_timeout_ctr.sv
// mem_timeout_ctr: clear/enable cycle counter with terminal-count flag.
//   clk, rst - clock, async active-low reset
//   clr_i    - synchronous clear (wins over en_i)
//   en_i     - count this cycle
//   tc_o     - high in the TIMEOUT_CYC-th enabled cycle since the last clear
module mem_timeout_ctr #(
  parameter int TIMEOUT_CYC = mem_stage_pkg::TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && cnt_q != CW'(TIMEOUT_CYC))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // cnt_q holds the number of enabled cycles already elapsed, so the
  // TIMEOUT_CYC-th enabled cycle is the one that sees TIMEOUT_CYC-1.
  assign tc_o = en_i && (cnt_q == CW'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage pipeline, between EX/MEM and MEM/WB.
// Issues one request per aligned load/store, stalls until Mem_Ack (or
// timeout), then presents the captured read data for one DONE cycle.
//   clk, rst          - clock, async active-low reset
//   Addr_FromX        - effective address       WriteData_FromX - store data
//   MemRead_FromX     - load in MEM slot        MemWrite_FromX  - store in MEM slot
//   WriteToReg_FromX  - instruction writes RF
//   mem (master)      - data-memory handshake (Mem_Req/Wr/Addr/WData/Ack/RData)
//   Mem_Stall         - freezes PC, IF/ID, ID/EX, EX/MEM
//   ReadData_ToW      - load data to MEM/WB (0 outside DONE)
//   WriteToReg_ToW    - gated RF write enable to MEM/WB
//   Err_Align         - misaligned access this cycle (combinational)
//   Err_Timeout       - sticky memory-timeout flag, cleared by reset only
//   Stall_Cnt         - saturating stall-cycle counter, present only when
//                       MEM_STALL_CNT_EN is defined
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] Addr_FromX,
  input  logic [DATA_W-1:0] WriteData_FromX,
  input  logic              MemRead_FromX,
  input  logic              MemWrite_FromX,
  input  logic              WriteToReg_FromX,
  mem_stage_if.master       mem,
  output logic              Mem_Stall,
  output logic [DATA_W-1:0] ReadData_ToW,
  output logic              WriteToReg_ToW,
  output logic              Err_Align,
  output logic              Err_Timeout
`ifdef MEM_STALL_CNT_EN
  ,
  output logic [15:0]       Stall_Cnt
`endif
);
  state_t            state_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_to_q;
  logic              access, req, tc;

  assign access    = MemRead_FromX | MemWrite_FromX;
  assign Err_Align = access & Addr_FromX[0];

  // Only IDLE issues; DONE still sees the same EX/MEM instruction and
  // must not re-issue it. Outputs are forced low while reset is held.
  assign req       = rst && (state_q == IDLE) && access && !Addr_FromX[0];
  assign Mem_Stall = req || (rst && state_q == BUSY);

  assign mem.Mem_Req   = req;
  assign mem.Mem_Wr    = MemWrite_FromX;   // load+store together acts as a store
  assign mem.Mem_Addr  = Addr_FromX;
  assign mem.Mem_WData = WriteData_FromX;

  assign ReadData_ToW   = (state_q == DONE) ? rdata_q : '0;
  assign WriteToReg_ToW = rst && WriteToReg_FromX && !Mem_Stall && !Err_Align;
  assign Err_Timeout    = err_to_q;

  mem_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_to (
    .clk   (clk),
    .rst   (rst),
    .clr_i (req),
    .en_i  (state_q == BUSY),
    .tc_o  (tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rdata_q  <= '0;
      err_to_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req) state_q <= BUSY;
        BUSY: begin
          // Ack takes priority over a coincident timeout.
          if (mem.Mem_Ack) begin
            rdata_q <= MemWrite_FromX ? '0 : mem.Mem_RData;
            state_q <= DONE;
          end else if (tc) begin
            err_to_q <= 1'b1;
            rdata_q  <= '0;
            state_q  <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MEM_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt_q <= '0;
    else if (Mem_Stall && stall_cnt_q != 16'hFFFF)
      stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign Stall_Cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] Addr_FromX = '0, WriteData_FromX = '0;
  logic        MemRead_FromX = 1'b0, MemWrite_FromX = 1'b0, WriteToReg_FromX = 1'b0;
  logic        Mem_Stall, WriteToReg_ToW, Err_Align, Err_Timeout;
  logic [15:0] ReadData_ToW;
`ifdef MEM_STALL_CNT_EN
  logic [15:0] Stall_Cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;

  mem_stage_if #(.DATA_W(16)) mif ();

  mem_stage #(.DATA_W(16), .TIMEOUT_CYC(15)) dut (
    .clk              (clk),
    .rst              (rst),
    .Addr_FromX       (Addr_FromX),
    .WriteData_FromX  (WriteData_FromX),
    .MemRead_FromX    (MemRead_FromX),
    .MemWrite_FromX   (MemWrite_FromX),
    .WriteToReg_FromX (WriteToReg_FromX),
    .mem              (mif.master),
    .Mem_Stall        (Mem_Stall),
    .ReadData_ToW     (ReadData_ToW),
    .WriteToReg_ToW   (WriteToReg_ToW),
    .Err_Align        (Err_Align),
    .Err_Timeout      (Err_Timeout)
`ifdef MEM_STALL_CNT_EN
    ,
    .Stall_Cnt        (Stall_Cnt)
`endif
  );

  always #5 clk = ~clk;

  // Results of the most recent run_access call.
  int          r_req, r_stall;
  logic        r_req_first, r_req_done, r_wr, r_wtr, r_wtr_early, r_align, r_to;
  logic [15:0] r_addr, r_wdata, r_rd;

  // Drives one instruction into the MEM slot (kind: 0 none, 1 load,
  // 2 store, 3 both) and acts as memory, pulsing Mem_Ack ack_delay cycles
  // after the request (0 = never). Runs until the first non-stall cycle.
  // Entered and left at posedge+1.
  task automatic run_access(input int kind, input logic [15:0] addr,
                            input logic [15:0] wdata, input int ack_delay,
                            input logic [15:0] rdata);
    r_req = 0; r_stall = 0; r_req_first = 0; r_req_done = 0; r_wr = 0;
    r_wtr = 0; r_wtr_early = 0; r_align = 0; r_to = 0;
    r_addr = '0; r_wdata = '0; r_rd = 16'hxxxx;
    MemRead_FromX    = (kind == 1 || kind == 3);
    MemWrite_FromX   = (kind == 2 || kind == 3);
    WriteToReg_FromX = (kind != 2 && kind != 3);
    Addr_FromX       = addr;
    WriteData_FromX  = wdata;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) r_req_first = mif.Mem_Req;
      if (mif.Mem_Req) begin
        r_req++; r_wr = mif.Mem_Wr; r_addr = mif.Mem_Addr; r_wdata = mif.Mem_WData;
      end
      if (Mem_Stall) begin
        r_stall++;
        if (WriteToReg_ToW) r_wtr_early = 1'b1;
      end else begin
        r_rd = ReadData_ToW; r_wtr = WriteToReg_ToW; r_align = Err_Align;
        r_req_done = mif.Mem_Req; r_to = Err_Timeout;
        break;
      end
      @(posedge clk); #1;
      mif.Mem_Ack   = (ack_delay > 0 && c + 1 == ack_delay);
      mif.Mem_RData = mif.Mem_Ack ? rdata : 16'h0000;
    end
    @(posedge clk); #1;
    MemRead_FromX = 0; MemWrite_FromX = 0; WriteToReg_FromX = 0;
    mif.Mem_Ack = 0; mif.Mem_RData = '0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    // Aligned load present during reset must not issue or stall.
    MemRead_FromX = 1; WriteToReg_FromX = 1; Addr_FromX = 16'h0040;
    mif.Mem_Ack = 0; mif.Mem_RData = '0;
    repeat (2) @(negedge clk);
    n_chk++; if (mif.Mem_Req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b exp 0", mif.Mem_Req); end
    n_chk++; if (Mem_Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b exp 0", Mem_Stall); end
    n_chk++; if (WriteToReg_ToW !== 1'b0) begin n_fail++; $display("FAIL reset_wtr: got %b exp 0", WriteToReg_ToW); end
    n_chk++; if (Err_Timeout !== 1'b0) begin n_fail++; $display("FAIL reset_errto: got %b exp 0", Err_Timeout); end
    n_chk++; if (ReadData_ToW !== 16'h0) begin n_fail++; $display("FAIL reset_rdata: got %h exp 0000", ReadData_ToW); end
    MemRead_FromX = 0; WriteToReg_FromX = 0;
    rst = 1;
    idle_cycle();
  endtask

  task automatic test_load_delay1();
    run_access(1, 16'h0010, 16'h0, 1, 16'hBEEF);
    n_chk++; if (r_req !== 1) begin n_fail++; $display("FAIL load1_req_cycles: got %0d exp 1", r_req); end
    n_chk++; if (r_stall !== 2) begin n_fail++; $display("FAIL load1_stall_cycles: got %0d exp 2", r_stall); end
    n_chk++; if (r_wr !== 1'b0 || r_addr !== 16'h0010) begin n_fail++; $display("FAIL load1_bus: got wr=%b addr=%h exp wr=0 addr=0010", r_wr, r_addr); end
    n_chk++; if (r_rd !== 16'hBEEF) begin n_fail++; $display("FAIL load1_rdata: got %h exp beef", r_rd); end
    n_chk++; if (r_wtr !== 1'b1 || r_wtr_early !== 1'b0) begin n_fail++; $display("FAIL load1_wtr: got done=%b early=%b exp 1/0", r_wtr, r_wtr_early); end
    // Cycle after DONE: read data returns to 0.
    @(negedge clk);
    n_chk++; if (ReadData_ToW !== 16'h0) begin n_fail++; $display("FAIL load1_rdata_after: got %h exp 0000", ReadData_ToW); end
    idle_cycle();
  endtask

  task automatic test_store_delay4();
    run_access(2, 16'h0020, 16'h1234, 4, 16'hFFFF);
    n_chk++; if (r_req !== 1) begin n_fail++; $display("FAIL store_req_cycles: got %0d exp 1", r_req); end
    n_chk++; if (r_wr !== 1'b1 || r_wdata !== 16'h1234) begin n_fail++; $display("FAIL store_bus: got wr=%b wdata=%h exp 1/1234", r_wr, r_wdata); end
    n_chk++; if (r_stall !== 5) begin n_fail++; $display("FAIL store_stall_cycles: got %0d exp 5", r_stall); end
    n_chk++; if (r_rd !== 16'h0) begin n_fail++; $display("FAIL store_rdata: got %h exp 0000", r_rd); end
    idle_cycle();
  endtask

  task automatic test_misaligned();
    run_access(1, 16'h0011, 16'h0, 1, 16'hAAAA);
    n_chk++; if (r_align !== 1'b1) begin n_fail++; $display("FAIL misalign_err: got %b exp 1", r_align); end
    n_chk++; if (r_req !== 0 || r_stall !== 0) begin n_fail++; $display("FAIL misalign_req_stall: got req=%0d stall=%0d exp 0/0", r_req, r_stall); end
    n_chk++; if (r_wtr !== 1'b0) begin n_fail++; $display("FAIL misalign_wtr: got %b exp 0", r_wtr); end
    // FSM must still be IDLE: an aligned load now stalls exactly 2 cycles.
    run_access(1, 16'h0012, 16'h0, 1, 16'h0F0F);
    n_chk++; if (r_stall !== 2 || r_rd !== 16'h0F0F) begin n_fail++; $display("FAIL misalign_next: got stall=%0d rd=%h exp 2/0f0f", r_stall, r_rd); end
    idle_cycle();
  endtask

  task automatic test_passthrough();
    // Non-memory op with an odd ALU result: no align error, no stall.
    run_access(0, 16'h0033, 16'h0, 1, 16'h0);
    n_chk++; if (r_req !== 0 || r_stall !== 0 || r_align !== 1'b0) begin n_fail++; $display("FAIL nonmem: got req=%0d stall=%0d align=%b exp 0/0/0", r_req, r_stall, r_align); end
    n_chk++; if (r_wtr !== 1'b1) begin n_fail++; $display("FAIL nonmem_wtr: got %b exp 1", r_wtr); end
    // Read and write together behave as a store.
    run_access(3, 16'h0044, 16'h5678, 2, 16'h9999);
    n_chk++; if (r_wr !== 1'b1 || r_rd !== 16'h0 || r_stall !== 3) begin n_fail++; $display("FAIL both_as_store: got wr=%b rd=%h stall=%0d exp 1/0000/3", r_wr, r_rd, r_stall); end
    idle_cycle();
  endtask

  task automatic test_ack_at_timeout();
    // Ack in the 15th BUSY cycle coincides with terminal count: Ack wins.
    run_access(1, 16'h0050, 16'h0, 15, 16'h7777);
    n_chk++; if (r_stall !== 16 || r_rd !== 16'h7777) begin n_fail++; $display("FAIL ack_at_tc: got stall=%0d rd=%h exp 16/7777", r_stall, r_rd); end
    n_chk++; if (r_to !== 1'b0) begin n_fail++; $display("FAIL ack_at_tc_errto: got %b exp 0", r_to); end
    idle_cycle();
  endtask

  task automatic test_timeout();
    run_access(1, 16'h0060, 16'h0, 0, 16'h0);
    n_chk++; if (r_stall !== 16) begin n_fail++; $display("FAIL timeout_stall: got %0d exp 16", r_stall); end
    n_chk++; if (r_to !== 1'b1 || r_rd !== 16'h0) begin n_fail++; $display("FAIL timeout_done: got errto=%b rd=%h exp 1/0000", r_to, r_rd); end
    idle_cycle();
    run_access(1, 16'h0062, 16'h0, 2, 16'h5A5A);
    n_chk++; if (r_req !== 1 || r_rd !== 16'h5A5A) begin n_fail++; $display("FAIL timeout_next: got req=%0d rd=%h exp 1/5a5a", r_req, r_rd); end
    n_chk++; if (r_to !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b exp 1", r_to); end
    idle_cycle();
  endtask

  task automatic test_reset_in_busy();
    MemRead_FromX = 1; WriteToReg_FromX = 1; Addr_FromX = 16'h0070;
    idle_cycle();   // request cycle
    idle_cycle();   // first BUSY cycle
    #2 rst = 0;
    #1;
    n_chk++; if (Mem_Stall !== 1'b0 || mif.Mem_Req !== 1'b0) begin n_fail++; $display("FAIL rstbusy_stall: got stall=%b req=%b exp 0/0", Mem_Stall, mif.Mem_Req); end
    n_chk++; if (Err_Timeout !== 1'b0) begin n_fail++; $display("FAIL rstbusy_errto: got %b exp 0", Err_Timeout); end
    MemRead_FromX = 0; WriteToReg_FromX = 0;
    @(negedge clk); rst = 1;
    @(posedge clk); #1; mif.Mem_Ack = 1; mif.Mem_RData = 16'hCAFE;
    @(negedge clk);
    n_chk++; if (Mem_Stall !== 1'b0 || ReadData_ToW !== 16'h0) begin n_fail++; $display("FAIL rstbusy_lateack: got stall=%b rd=%h exp 0/0000", Mem_Stall, ReadData_ToW); end
    @(posedge clk); #1; mif.Mem_Ack = 0; mif.Mem_RData = '0;
    @(negedge clk);
    n_chk++; if (ReadData_ToW !== 16'h0) begin n_fail++; $display("FAIL rstbusy_ignored: got rd=%h exp 0000", ReadData_ToW); end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    run_access(1, 16'h0030, 16'h0, 1, 16'h1111);
    n_chk++; if (r_rd !== 16'h1111 || r_req_done !== 1'b0) begin n_fail++; $display("FAIL b2b_first: got rd=%h req_in_done=%b exp 1111/0", r_rd, r_req_done); end
    run_access(1, 16'h0032, 16'h0, 1, 16'h2222);
    n_chk++; if (r_req_first !== 1'b1 || r_req !== 1) begin n_fail++; $display("FAIL b2b_second_req: got first=%b cnt=%0d exp 1/1", r_req_first, r_req); end
    n_chk++; if (r_rd !== 16'h2222 || r_req_done !== 1'b0 || r_stall !== 2) begin n_fail++; $display("FAIL b2b_second: got rd=%h req_in_done=%b stall=%0d exp 2222/0/2", r_rd, r_req_done, r_stall); end
`ifdef MEM_STALL_CNT_EN
    n_chk++; if (Stall_Cnt !== 16'd4) begin n_fail++; $display("FAIL stall_cnt: got %0d exp 4", Stall_Cnt); end
`endif
    idle_cycle();
  endtask

  initial begin
    mif.Mem_Ack = 0; mif.Mem_RData = '0;
    test_reset();
    test_load_delay1();
    test_store_delay4();
    test_misaligned();
    test_passthrough();
    test_ack_at_timeout();
    test_timeout();
    test_reset_in_busy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end
endmodule
